// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multicycle ALU with valid/ready handshake and registered result/flags
// Restoring divider (opcode 7) is built only when ALU_MULTICYCLE_DIV_EN is defined.
module alu_multicycle #(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             signFlag
);
  typedef enum logic [1:0] {IDLE, DIV_RUN, HOLD} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, sign_q;
  logic             load;
  logic             accept;
  logic [WIDTH-1:0] op_res;
  logic             op_carry;
  logic [WIDTH:0]   sum, diff;

  assign in_ready  = (state_q == IDLE) || (state_q == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign result    = result_q;
  assign carryFlag = carry_q;
  assign zeroFlag  = zero_q;
  assign signFlag  = sign_q;

  always_comb begin
    sum      = {1'b0, input1} + {1'b0, input2};
    diff     = {1'b0, input1} - {1'b0, input2};
    op_res   = '0;
    op_carry = 1'b0;
    case (opcode)
      4'd0: begin op_res = sum[WIDTH-1:0];  op_carry = sum[WIDTH];  end
      4'd1: begin op_res = diff[WIDTH-1:0]; op_carry = diff[WIDTH]; end
      4'd2: op_res = input1 & input2;
      4'd3: op_res = input1 | input2;
      4'd4: op_res = input1 << shiftValue;
      4'd5: op_res = ~(input1 ^ input2);
      4'd6: op_res = input2;
`ifdef ALU_MULTICYCLE_DIV_EN
      // Only reaches the single-cycle path for a zero divisor: divide-error marker.
      4'd7: op_carry = (input2 == '0);
`endif
      default: ;
    endcase
  end

`ifdef ALU_MULTICYCLE_DIV_EN
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q, quo_nx;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             take;
  logic             div_start;

  assign div_start = accept && (opcode == 4'd7) && (input2 != '0);

  // quo_q starts as the dividend; its MSBs shift into the remainder as quotient bits shift in.
  always_comb begin
    rem_sh  = {rem_q, quo_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, dvs_q};
    take    = (rem_sh >= {1'b0, dvs_q});
    quo_nx  = {quo_q[WIDTH-2:0], take};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (div_start) begin
      rem_q <= '0;
      quo_q <= input1;
      dvs_q <= input2;
      cnt_q <= SHW'(WIDTH - 1);
    end else if (state_q == DIV_RUN) begin
      rem_q <= take ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      quo_q <= quo_nx;
      cnt_q <= cnt_q - SHW'(1);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    load     = 1'b0;
    case (state_q)
      IDLE, HOLD: begin
        if (accept) begin
`ifdef ALU_MULTICYCLE_DIV_EN
          if (div_start) state_d = DIV_RUN;
          else
`endif
          begin
            state_d  = HOLD;
            result_d = op_res;
            carry_d  = op_carry;
            load     = 1'b1;
          end
        end else if (state_q == HOLD && out_ready) begin
          state_d = IDLE;
        end
      end
`ifdef ALU_MULTICYCLE_DIV_EN
      DIV_RUN: begin
        if (cnt_q == '0) begin
          state_d  = HOLD;
          result_d = quo_nx;
          carry_d  = 1'b0;
          load     = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        result_q <= result_d;
        carry_q  <= carry_d;
        zero_q   <= (result_d == '0);
        sign_q   <= result_d[WIDTH-1];
      end
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized scoreboard bench for alu_multicycle (WIDTH=64)
// Honours ALU_MULTICYCLE_DIV_EN the same way the design does.
module tb_alu_multicycle;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    opcode = '0;
  logic [W-1:0]  input1 = '0;
  logic [W-1:0]  input2 = '0;
  logic [5:0]    shiftValue = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          carryFlag, zeroFlag, signFlag;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .input1(input1), .input2(input2), .shiftValue(shiftValue),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .carryFlag(carryFlag), .zeroFlag(zeroFlag), .signFlag(signFlag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c, z, s;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic prev_ov = 1'b0, prev_hs = 1'b0;

`ifdef ALU_MULTICYCLE_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, b, input logic [5:0] sh);
    exp_t e;
    logic [W:0] wide;
    e.res = '0; e.c = 1'b0; e.lat = 1; e.acc = 0;
    case (op)
      4'd0: begin wide = {1'b0, a} + {1'b0, b}; e.res = wide[W-1:0]; e.c = wide[W]; end
      4'd1: begin e.res = a - b; e.c = (a < b); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a << sh;
      4'd5: e.res = ~(a ^ b);
      4'd6: e.res = b;
      4'd7: if (DIV_ON) begin
              if (b == 0) e.c = 1'b1;
              else begin e.res = a / b; e.lat = W + 1; end
            end
      default: ;
    endcase
    e.z = (e.res == 0);
    e.s = e.res[W-1];
    return e;
  endfunction

  // Scoreboard monitor: compares every cycle the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ov = 1'b0; prev_hs = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {63'b0, out_valid}, '0);
        end else begin
          e = exp_q[0];
          if (!prev_ov || prev_hs) chk("latency", W'(cyc - e.acc + 1), W'(e.lat));
          chk("result", result, e.res);
          chk("flags_czs", {61'b0, carryFlag, zeroFlag, signFlag}, {61'b0, e.c, e.z, e.s});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = out_valid;
      prev_hs = out_valid && out_ready;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, b, input logic [5:0] sh);
    exp_t e;
    @(posedge clk); #1;
    opcode = op; input1 = a; input2 = b; shiftValue = sh; in_valid = 1'b1;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 300) begin
        chk("accept_timeout", {63'b0, in_ready}, 64'd1);
        in_valid = 1'b0;
        return;
      end
    end
    e = model(op, a, b, sh);
    e.acc = cyc + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 4'($urandom); input1 = {$urandom, $urandom}; input2 = {$urandom, $urandom};
    shiftValue = 6'($urandom);
  endtask

  initial begin
    int n;
    logic [W-1:0] a, b;
    logic [3:0]   op;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, '0);
    chk("rst_result", result, '0);
    chk("rst_flags", {61'b0, carryFlag, zeroFlag, signFlag}, '0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    rst = 1'b0;

    rdy_mode = 0;
    issue(4'd0, {W{1'b1}}, 64'd1, 6'd0);
    issue(4'd1, 64'd5, 64'd7, 6'd0);
    issue(4'd4, 64'd1, 64'd0, 6'd63);
    issue(4'd7, 64'd77, 64'd0, 6'd0);
    issue(4'd12, 64'd9, 64'd3, 6'd0);
    issue(4'd7, 64'd9, 64'd3, 6'd0);

    // in_ready low for the whole divide; requests during it are ignored.
    issue(4'd7, 64'd100, 64'd7, 6'd0);
    n = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      in_valid = 1'b1; opcode = 4'd0; input1 = 64'd1; input2 = 64'd1;
    end
    in_valid = 1'b0;
    chk("div_busy_cycles", W'(n), DIV_ON ? W'(W) : '0);

    // Stall in HOLD, then overlap drain with a new request.
    @(negedge clk); rdy_mode = 2;
    issue(4'd5, 64'd0, 64'd0, 6'd0);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'b0, in_ready}, '0);
    end
    @(negedge clk); rdy_mode = 0;
    issue(4'd6, 64'hDEAD, 64'h1234, 6'd0);

    // Reset mid-operation discards everything.
    issue(4'd7, 64'd1000, 64'd3, 6'd0);
    repeat (19) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    exp_q.delete();
    chk("abort_out_valid", {63'b0, out_valid}, '0);
    chk("abort_result", result, '0);
    chk("abort_flags", {61'b0, carryFlag, zeroFlag, signFlag}, '0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (70) @(posedge clk);
    issue(4'd0, 64'd2, 64'd3, 6'd0);

    for (int i = 0; i < 120; i++) begin
      @(negedge clk); rdy_mode = $urandom_range(0, 1);
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'($urandom_range(0, 9));
        1:       b = {32'd0, $urandom};
        default: b = {$urandom, $urandom};
      endcase
      issue(op, a, b, 6'($urandom));
    end

    @(negedge clk); rdy_mode = 0;
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) @(negedge clk);
    chk("drain_pending", W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
